note_play_scheduler: RTL
========================

Name: note_play_scheduler

Overview:
- Owns the buzzer note path and shares it between three note sources: free-play, auto-play and learn.
- The one-hot mode word selects which source the block listens to.
- The selected source hands over one note at a time via a valid/ready handshake. The block plays the note for a timed duration, then inserts a silent articulation gap, then accepts the next note.
- Sits between the mode sub-blocks and the buzzer/LED/octave outputs, replacing direct per-mode output muxing.

Parameters:
- BEAT_CYCLES, 50_000_000, clock cycles per beat; must be even and >= 2.
- GAP_CYCLES, 5_000_000, silent cycles after every note; 0 disables the gap.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- mode  in  3  one-hot source select: 100 free, 010 auto, 001 learn; any other value selects no source
- hold  in  1  pause; freezes the PLAY/GAP counter and the outputs
- free_note, auto_note, learn_note  in  4 each  note code: 0 rest, 1-7 do..si, 8-15 treated as rest
- free_oct, auto_oct, learn_oct  in  2 each  octave for the note
- free_dur, auto_dur, learn_dur  in  2 each  duration code: 00 half beat, 01 one beat, 10 two beats, 11 four beats
- free_valid, auto_valid, learn_valid  in  1 each  source offers a note
- free_ready, auto_ready, learn_ready  out  1 each  accept strobe to the source
- note_out  out  4  note driven to the buzzer; 0 means silent
- octave_out  out  2  octave of the current note
- led_out  out  7  one-hot LED of the current note (bit n-1 for note n); 0 when silent
- busy  out  1  high in PLAY or GAP
- done  out  1  one-cycle pulse when a note completes its gap

Behaviour:
- States: IDLE, PLAY, GAP.
- Reset: state IDLE; note_out=0, octave_out=0, led_out=0, busy=0, done=0, all ready=0, counter=0.
- Ready is combinational: ready_x = (state==IDLE) & (mode selects x) & x_valid & ~reset. At most one ready is high. Non-selected sources never see ready.
- IDLE: when the selected source's valid is high (call this cycle T):
  - latch note, octave and duration;
  - load counter with D = BEAT_CYCLES/2, BEAT_CYCLES, 2*BEAT_CYCLES or 4*BEAT_CYCLES per the duration code;
  - go to PLAY.
- Hold is ignored in IDLE.
- PLAY, cycles T+1 .. T+D:
  - note_out = latched note, or 0 if the note is >7;
  - octave_out = latched octave;
  - led_out is the decoded LED;
  - busy=1.
  - Counter decrements each non-held cycle. When it reaches 1, next state is GAP, or IDLE if GAP_CYCLES=0.
- GAP, G=GAP_CYCLES cycles:
  - note_out=0, led_out=0; octave_out keeps its value; busy=1.
  - On the last gap cycle, next state is IDLE.
- done pulses for one cycle on the first IDLE cycle after a completed note. A new accept may occur in that same cycle. Back-to-back note period = D+G+1 cycles.
- hold=1 in PLAY/GAP: counter, state and outputs are frozen; done and ready stay 0.
- Mode change in PLAY:
  - abort immediately to GAP; the full GAP_CYCLES are played, or go directly to IDLE if G=0;
  - done is not pulsed for an aborted note.
- Mode change in GAP: the gap completes normally.
- Invalid mode in IDLE: no ready, outputs silent. Invalid mode in PLAY counts as a mode change.
- Valid deasserted while in PLAY/GAP is ignored; the note was already accepted.
- Reset mid-note returns to the reset values on the next edge; no done pulse.
- Counter width is $clog2(4*BEAT_CYCLES+1), and also covers GAP_CYCLES. All multiplies are constant shifts.

Decomposition:
- Package note_sched_pkg:
  - mode constants MODE_FREE=3'b100, MODE_AUTO=3'b010, MODE_LEARN=3'b001;
  - duration code constants;
  - state enum {IDLE, PLAY, GAP};
  - function note_to_led (4-bit code to 7-bit one-hot).
- Sub-module note_timer: loadable down-counter with load, en (driven by ~hold) and a last-cycle flag. It is reused for both the PLAY and GAP phases.

Test Plan (BEAT_CYCLES=8, GAP_CYCLES=2):
- Auto source: mode=010, auto_valid with note 3, oct 2, dur 01 accepted at T -> auto_ready=1 only at T; note_out=3, led_out=0000100, octave_out=2 for T+1..T+8; note_out=0 for T+9..T+10; done=1 at T+11.
- Back-to-back learn notes with dur 00 then 11 -> second ready in the same cycle as the first done; plays last 4 then 32 cycles; period between accepts = 4+2+1 = 7.
- Hold asserted for 5 cycles mid-PLAY of a 1-beat note -> note lasts 13 cycles; done is delayed by 5 cycles.
- Mode switched 010->100 at the 3rd PLAY cycle -> note_out=0 next cycle; 2 gap cycles; no done pulse; then free_ready asserts if free_valid is high.
- mode=011 with all valids high -> all ready=0, note_out=0, busy=0 indefinitely.
- Note code 9, dur 01 -> note_out=0, led_out=0 for 8 cycles, busy=1, done pulses; reset asserted mid-PLAY of another note -> all outputs 0 next cycle, no done.

Source files
------------

// File: rtl/note_sched_pkg.sv
// Shared definitions for the note play scheduler.
//   - one-hot source select codes for the mode word
//   - duration codes carried with each note
//   - scheduler state encoding
//   - note code helpers (buzzer code and LED decode)
package note_sched_pkg;

  localparam logic [2:0] MODE_FREE  = 3'b100;
  localparam logic [2:0] MODE_AUTO  = 3'b010;
  localparam logic [2:0] MODE_LEARN = 3'b001;

  localparam logic [1:0] DUR_HALF = 2'b00;
  localparam logic [1:0] DUR_ONE  = 2'b01;
  localparam logic [1:0] DUR_TWO  = 2'b10;
  localparam logic [1:0] DUR_FOUR = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    GAP
  } sched_state_t;

  // Codes 8-15 are not notes; they sound as a rest.
  function automatic logic [3:0] play_code(input logic [3:0] note);
    play_code = (note > 4'd7) ? 4'd0 : note;
  endfunction

  // One-hot LED for notes 1..7 (bit n-1 for note n); dark otherwise.
  function automatic logic [6:0] note_to_led(input logic [3:0] note);
    note_to_led = '0;
    if (note != 4'd0 && note <= 4'd7)
      note_to_led = 7'b1 << (note[2:0] - 3'd1);
  endfunction

endpackage

// File: rtl/note_timer.sv
// Loadable down-counter timing one PLAY or GAP phase.
//   clk, reset : clock, synchronous active-high reset
//   load       : load value into the counter (wins over en)
//   en         : count down one step (held low while paused)
//   value      : phase length in cycles
//   last       : high while the counter sits at 1, i.e. final phase cycle
module note_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] value,
  output logic         last
);

  logic [W-1:0] count;

  // NOTE: sequential state is written with non-blocking assignments only,
  // so every register samples its inputs from the same clock edge.
  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (load)
      count <= value;
    else if (en && count != '0)
      count <= count - 1'b1;
  end

  assign last = (count == W'(1));

endmodule

// File: rtl/note_play_scheduler.sv
// Shares the buzzer note path between the free-play, auto-play and learn
// sources. The source picked by the one-hot mode word hands over one note
// via valid/ready; the note plays for its duration, a silent gap follows,
// then the next note is accepted.
//   clk, reset            : clock, synchronous active-high reset
//   mode                  : 100 free, 010 auto, 001 learn, else no source
//   hold                  : pause; freezes timing and outputs in PLAY/GAP
//   <src>_note/oct/dur    : note code, octave, duration code per source
//   <src>_valid/_ready    : per-source handshake (ready is combinational)
//   note_out, octave_out  : buzzer note (0 = silent) and its octave
//   led_out               : one-hot LED of the sounding note
//   busy                  : high in PLAY or GAP
//   done                  : one-cycle pulse when a note finishes its gap
module note_play_scheduler
  import note_sched_pkg::*;
#(
  parameter int BEAT_CYCLES = 50_000_000,
  parameter int GAP_CYCLES  = 5_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] mode,
  input  logic       hold,
  input  logic [3:0] free_note,
  input  logic [3:0] auto_note,
  input  logic [3:0] learn_note,
  input  logic [1:0] free_oct,
  input  logic [1:0] auto_oct,
  input  logic [1:0] learn_oct,
  input  logic [1:0] free_dur,
  input  logic [1:0] auto_dur,
  input  logic [1:0] learn_dur,
  input  logic       free_valid,
  input  logic       auto_valid,
  input  logic       learn_valid,
  output logic       free_ready,
  output logic       auto_ready,
  output logic       learn_ready,
  output logic [3:0] note_out,
  output logic [1:0] octave_out,
  output logic [6:0] led_out,
  output logic       busy,
  output logic       done
);

  // The counter must hold the longest note and the gap length.
  localparam int MAX_CYCLES = (4 * BEAT_CYCLES > GAP_CYCLES) ? 4 * BEAT_CYCLES : GAP_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0] CYC_ONE  = CW'(BEAT_CYCLES);
  localparam logic [CW-1:0] CYC_HALF = CYC_ONE >> 1;
  localparam logic [CW-1:0] CYC_TWO  = CYC_ONE << 1;
  localparam logic [CW-1:0] CYC_FOUR = CYC_ONE << 2;
  localparam logic [CW-1:0] CYC_GAP  = CW'(GAP_CYCLES);
  localparam bit            NO_GAP   = (GAP_CYCLES == 0);

  sched_state_t state;
  logic [2:0]   cur_mode;   // source that owns the note being played
  logic         aborted;    // current note was cut short by a mode change

  logic       sel_valid;
  logic [3:0] sel_note;
  logic [1:0] sel_oct;
  logic [1:0] sel_dur;

  logic          accept, abort, play_end, gap_end;
  logic          timer_load, timer_en, timer_last;
  logic [CW-1:0] timer_value;

  // NOTE: every signal written here gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    sel_valid = 1'b0;
    sel_note  = '0;
    sel_oct   = '0;
    sel_dur   = '0;
    case (mode)
      MODE_FREE:  begin sel_valid = free_valid;  sel_note = free_note;  sel_oct = free_oct;  sel_dur = free_dur;  end
      MODE_AUTO:  begin sel_valid = auto_valid;  sel_note = auto_note;  sel_oct = auto_oct;  sel_dur = auto_dur;  end
      MODE_LEARN: begin sel_valid = learn_valid; sel_note = learn_note; sel_oct = learn_oct; sel_dur = learn_dur; end
      default: ;
    endcase
  end

  assign free_ready  = ~reset & (state == IDLE) & (mode == MODE_FREE)  & free_valid;
  assign auto_ready  = ~reset & (state == IDLE) & (mode == MODE_AUTO)  & auto_valid;
  assign learn_ready = ~reset & (state == IDLE) & (mode == MODE_LEARN) & learn_valid;

  // Hold takes priority over a mode change: a paused note stays frozen.
  assign accept   = (state == IDLE) & sel_valid;
  assign abort    = (state == PLAY) & ~hold & (mode != cur_mode);
  assign play_end = (state == PLAY) & ~hold & ~abort & timer_last;
  assign gap_end  = (state == GAP)  & ~hold & timer_last;

  assign timer_load = accept | abort | play_end;
  assign timer_en   = ~hold & (state != IDLE);

  always_comb begin
    timer_value = CYC_GAP;
    if (accept) begin
      case (sel_dur)
        DUR_HALF: timer_value = CYC_HALF;
        DUR_ONE:  timer_value = CYC_ONE;
        DUR_TWO:  timer_value = CYC_TWO;
        DUR_FOUR: timer_value = CYC_FOUR;
        default:  timer_value = CYC_ONE;
      endcase
    end
  end

  note_timer #(.W(CW)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (timer_load),
    .en    (timer_en),
    .value (timer_value),
    .last  (timer_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cur_mode   <= '0;
      aborted    <= 1'b0;
      note_out   <= '0;
      octave_out <= '0;
      led_out    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          note_out <= '0;
          led_out  <= '0;
          busy     <= 1'b0;
          if (accept) begin
            state      <= PLAY;
            cur_mode   <= mode;
            aborted    <= 1'b0;
            note_out   <= play_code(sel_note);
            led_out    <= note_to_led(sel_note);
            octave_out <= sel_oct;
            busy       <= 1'b1;
          end
        end
        PLAY: begin
          if (abort || play_end) begin
            note_out <= '0;
            led_out  <= '0;
            aborted  <= abort;
            if (NO_GAP) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= play_end;
            end else begin
              state <= GAP;
            end
          end
        end
        GAP: begin
          if (gap_end) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= ~aborted;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
